// File: rtl/zelda_audio_pkg.sv
// Shared audio constants and FSM state type for the lullaby player.
// Used by the tone synthesizer and by the music sequencer note tables.
package zelda_audio_pkg;

   localparam int unsigned CLK_HZ         = 50_000_000;
   localparam int unsigned CW             = 28;
   // 50 ms articulation gap and 125 ms decay step at CLK_HZ
   localparam int unsigned GAP_CYCLES_DEF = CLK_HZ / 20;
   localparam int unsigned DECAY_CYC_DEF  = CLK_HZ / 8;
   localparam int unsigned VOL_W_DEF      = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } audio_state_e;

endpackage

// File: rtl/tone_phase_counter.sv
// Tone divider: toggles the square-wave phase sq every half_period enabled cycles.
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   half_period  cycles per half-period (1 toggles sq every enabled cycle)
//   clear        restarts the phase: counter and sq go to 0
//   enable       advance the divider this cycle
//   sq           square-wave phase
module tone_phase_counter
   import zelda_audio_pkg::*;
#(
   parameter int unsigned W = CW
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [W-1:0] half_period,
   input  logic         clear,
   input  logic         enable,
   output logic         sq
);

   logic [W-1:0] tone_cnt;

   // Half-period counter; clear has priority so a new note always starts at phase 0
   always_ff @(posedge Clk) begin
      if (Reset || clear) begin
         tone_cnt <= '0;
         sq       <= 1'b0;
      end else if (enable) begin
         if (tone_cnt == half_period - W'(1)) begin
            tone_cnt <= '0;
            sq       <= ~sq;
         end else begin
            tone_cnt <= tone_cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/buzzer_tone_synth.sv
// Piezo tone synthesizer: plays one note at a time as a PWM-gated square wave
// followed by a silent articulation gap, with phase-clean note boundaries.
// Optional feature macro: ENVELOPE_DECAY_EN (volume decays one step every
// DECAY_CYC cycles of PLAY, floor 1 for a nonzero start volume).
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   note_valid   1-cycle strobe: latch half_period/note_len/volume and start note
//   half_period  cycles per tone half-period, 0 = rest
//   note_len     note duration in cycles including the gap
//   volume       0 = mute, all ones = always on, else duty volume/2^VOL_W
//   Buzzer       registered gated square wave
//   busy         high while in PLAY or GAP
//   note_done    1-cycle pulse when a note's duration expires
module buzzer_tone_synth
   import zelda_audio_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
`ifdef ENVELOPE_DECAY_EN
   parameter int unsigned DECAY_CYC  = DECAY_CYC_DEF,
`endif
   parameter int unsigned VOL_W      = VOL_W_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             note_valid,
   input  logic [CW-1:0]    half_period,
   input  logic [CW-1:0]    note_len,
   input  logic [VOL_W-1:0] volume,
   output logic             Buzzer,
   output logic             busy,
   output logic             note_done
);

   localparam logic [CW-1:0]    GAP_LEN = CW'(GAP_CYCLES);
   localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

   audio_state_e     state;
   logic [CW-1:0]    dur_cnt;
   logic [CW-1:0]    hp_q;
   logic [CW-1:0]    len_q;
   logic [VOL_W-1:0] pwm_cnt;
   logic [VOL_W-1:0] vol_eff;
   logic             sq;

   logic [CW-1:0]    play_last_c;
   logic             gap_last_c;
   logic             pwm_on_c;
   logic             tone_clear_c;
   logic             tone_en_c;

   // Last PLAY cycle index; only meaningful when the note is longer than the gap
   assign play_last_c  = (len_q > GAP_LEN) ? (len_q - GAP_LEN - CW'(1)) : '0;
   // A zero-length note expires on its first GAP cycle instead of wrapping
   assign gap_last_c   = (len_q == '0) || (dur_cnt == len_q - CW'(1));
   assign pwm_on_c     = (vol_eff == VOL_MAX) || (pwm_cnt < vol_eff);
   assign tone_clear_c = note_valid || (state != PLAY);
   assign tone_en_c    = (state == PLAY) && (hp_q != '0);

   tone_phase_counter #(
      .W (CW)
   ) u_phase (
      .Clk         (Clk),
      .Reset       (Reset),
      .half_period (hp_q),
      .clear       (tone_clear_c),
      .enable      (tone_en_c),
      .sq          (sq)
   );

   // Note FSM, duration counter, free-running PWM counter and registered outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         dur_cnt   <= '0;
         hp_q      <= '0;
         len_q     <= '0;
         pwm_cnt   <= '0;
         busy      <= 1'b0;
         note_done <= 1'b0;
         Buzzer    <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + VOL_W'(1);
         note_done <= 1'b0;
         Buzzer    <= (state == PLAY) && (hp_q != '0) && sq && pwm_on_c;
         if (note_valid) begin
            // New note preempts anything in flight, including a gap expiring now
            hp_q    <= half_period;
            len_q   <= note_len;
            dur_cnt <= '0;
            state   <= (note_len > GAP_LEN) ? PLAY : GAP;
            busy    <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               PLAY: begin
                  dur_cnt <= dur_cnt + CW'(1);
                  if (dur_cnt == play_last_c) begin
                     state <= GAP;
                  end
               end
               GAP: begin
                  dur_cnt <= dur_cnt + CW'(1);
                  if (gap_last_c) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     note_done <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef ENVELOPE_DECAY_EN
   localparam int unsigned DW = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;

   logic [DW-1:0] decay_cnt;

   // Envelope: reload on note start, step down every DECAY_CYC PLAY cycles
   always_ff @(posedge Clk) begin
      if (Reset) begin
         decay_cnt <= '0;
         vol_eff   <= '0;
      end else if (note_valid) begin
         decay_cnt <= '0;
         vol_eff   <= volume;
      end else if (state == PLAY) begin
         if (decay_cnt == DW'(DECAY_CYC - 1)) begin
            decay_cnt <= '0;
            if (vol_eff > VOL_W'(1)) begin
               vol_eff <= vol_eff - VOL_W'(1);
            end
         end else begin
            decay_cnt <= decay_cnt + DW'(1);
         end
      end
   end
`else
   // Constant volume for the whole note
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vol_eff <= '0;
      end else if (note_valid) begin
         vol_eff <= volume;
      end
   end
`endif

endmodule

// File: tb/tb_buzzer_tone_synth.sv
// Self-checking bench for buzzer_tone_synth with a short gap and decay step.
module tb_buzzer_tone_synth;

   localparam int unsigned CW    = 28;
   localparam int unsigned VOL_W = 3;
   localparam int          GAP   = 4;
   localparam int          DECAY = 8;
   localparam int          PWM_N = 1 << VOL_W;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic             note_valid = 1'b0;
   logic [CW-1:0]    half_period = '0;
   logic [CW-1:0]    note_len = '0;
   logic [VOL_W-1:0] volume = '0;
   logic             Buzzer;
   logic             busy;
   logic             note_done;

   int checks = 0;
   int errors = 0;
   int pwm_edges = 0;
   int note_e = 0;

   buzzer_tone_synth #(
      .GAP_CYCLES (GAP),
`ifdef ENVELOPE_DECAY_EN
      .DECAY_CYC  (DECAY),
`endif
      .VOL_W      (VOL_W)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .note_valid  (note_valid),
      .half_period (half_period),
      .note_len    (note_len),
      .volume      (volume),
      .Buzzer      (Buzzer),
      .busy        (busy),
      .note_done   (note_done)
   );

   always #10 Clk = ~Clk;

   // Cycles since reset release: the phase of the free-running PWM
   always @(posedge Clk) begin
      if (Reset) pwm_edges <= 0;
      else       pwm_edges <= pwm_edges + 1;
   end

   // Effective volume j cycles into PLAY
   function automatic int vol_at(input int vol, input int j);
`ifdef ENVELOPE_DECAY_EN
      int v;
      if (vol == 0) return 0;
      v = vol - j / DECAY;
      return (v < 1) ? 1 : v;
`else
      return vol;
`endif
   endfunction

   // Expected Buzzer k cycles after the latch edge; it reflects cycle k-1 of the note
   function automatic bit exp_buzz(input int hp, input int len, input int vol,
                                   input int e, input int k);
      int j;
      int play_len;
      int v;
      int p;
      j        = k - 1;
      play_len = (len > GAP) ? len - GAP : 0;
      if (k < 1 || j >= play_len || hp == 0) return 1'b0;
      if (((j / hp) % 2) == 0) return 1'b0;
      v = vol_at(vol, j);
      p = (e + j) % PWM_N;
      return (v == PWM_N - 1) || (p < v);
   endfunction

   // Strobe a note at the current negedge; returns at the negedge of note cycle 0
   task automatic launch(input int hp, input int len, input int vol);
      half_period = CW'(hp);
      note_len    = CW'(len);
      volume      = VOL_W'(vol);
      note_valid  = 1'b1;
      @(negedge Clk);
      note_valid  = 1'b0;
      note_e      = pwm_edges;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         checks++;
         if ({Buzzer, busy, note_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d: got buz/busy/done=%b%b%b expected 000",
                     i, Buzzer, busy, note_done);
         end
         note_valid  = 1'($urandom);
         half_period = CW'($urandom_range(1, 5));
         note_len    = CW'($urandom_range(0, 30));
         volume      = VOL_W'($urandom);
      end
      Reset      = 1'b0;
      note_valid = 1'b0;
      @(negedge Clk);
      checks++;
      if ({Buzzer, busy, note_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: got buz/busy/done=%b%b%b expected 000",
                  Buzzer, busy, note_done);
      end
   endtask

   task automatic test_basic();
      int hps[3]  = '{3, 1, 2};
      int lens[3] = '{20, 13, 9};
      for (int n = 0; n < 3; n++) begin
         launch(hps[n], lens[n], 7);
         for (int k = 0; k <= lens[n] + 1; k++) begin
            if (k > 0) @(negedge Clk);
            checks++;
            if (Buzzer !== exp_buzz(hps[n], lens[n], 7, note_e, k)) begin
               errors++;
               $display("FAIL basic_buzzer n=%0d k=%0d: got %b expected %b",
                        n, k, Buzzer, exp_buzz(hps[n], lens[n], 7, note_e, k));
            end
            checks++;
            if (busy !== (k < lens[n]) || note_done !== (k == lens[n])) begin
               errors++;
               $display("FAIL basic_ctl n=%0d k=%0d: got busy/done=%b%b expected %b%b",
                        n, k, busy, note_done, k < lens[n], k == lens[n]);
            end
         end
      end
   endtask

   task automatic test_rest_and_short();
      int hps[6]  = '{0, 1, 1, 1, 1, 2};
      int lens[6] = '{10, 0, 3, 4, 5, 6};
      int last;
      for (int n = 0; n < 6; n++) begin
         last = (lens[n] < 1) ? 1 : lens[n];
         launch(hps[n], lens[n], 7);
         for (int k = 0; k <= last + 1; k++) begin
            if (k > 0) @(negedge Clk);
            checks++;
            if (Buzzer !== exp_buzz(hps[n], lens[n], 7, note_e, k)) begin
               errors++;
               $display("FAIL short_buzzer len=%0d k=%0d: got %b expected %b",
                        lens[n], k, Buzzer, exp_buzz(hps[n], lens[n], 7, note_e, k));
            end
            checks++;
            if (busy !== (k < last) || note_done !== (k == last)) begin
               errors++;
               $display("FAIL short_ctl len=%0d k=%0d: got busy/done=%b%b expected %b%b",
                        lens[n], k, busy, note_done, k < last, k == last);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int ea;
      // Preempt a 20-cycle note in its cycle 4, then collide a strobe with gap expiry
      launch(3, 20, 7);
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) @(negedge Clk);
         checks++;
         if (busy !== 1'b1 || note_done !== 1'b0) begin
            errors++;
            $display("FAIL preempt_first k=%0d: got busy/done=%b%b expected 10", k, busy, note_done);
         end
      end
      ea = note_e;
      launch(2, 20, 7);
      checks++;
      if (Buzzer !== exp_buzz(3, 20, 7, ea, 5)) begin
         errors++;
         $display("FAIL preempt_carry: got %b expected %b", Buzzer, exp_buzz(3, 20, 7, ea, 5));
      end
      for (int k = 0; k <= 21; k++) begin
         if (k > 0) @(negedge Clk);
         checks++;
         if (k > 0 && Buzzer !== exp_buzz(2, 20, 7, note_e, k)) begin
            errors++;
            $display("FAIL preempt_buzzer k=%0d: got %b expected %b",
                     k, Buzzer, exp_buzz(2, 20, 7, note_e, k));
         end
         checks++;
         if (busy !== (k < 20) || note_done !== (k == 20)) begin
            errors++;
            $display("FAIL preempt_ctl k=%0d: got busy/done=%b%b expected %b%b",
                     k, busy, note_done, k < 20, k == 20);
         end
      end
      launch(1, 8, 7);
      repeat (7) @(negedge Clk);
      launch(1, 9, 7);
      checks++;
      if (busy !== 1'b1 || note_done !== 1'b0) begin
         errors++;
         $display("FAIL collide: got busy/done=%b%b expected 10", busy, note_done);
      end
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         checks++;
         if (Buzzer !== exp_buzz(1, 9, 7, note_e, k) || note_done !== (k == 9)) begin
            errors++;
            $display("FAIL collide_next k=%0d: got buz/done=%b%b expected %b%b",
                     k, Buzzer, note_done, exp_buzz(1, 9, 7, note_e, k), k == 9);
         end
      end
   endtask

   task automatic test_volume();
      int vols[3] = '{2, 0, 5};
      int hps[3]  = '{64, 2, 1};
      int lens[3] = '{200, 60, 80};
      int highs;
      int want;
      for (int n = 0; n < 3; n++) begin
         highs = 0;
         launch(hps[n], lens[n], vols[n]);
         for (int k = 0; k <= lens[n] + 1; k++) begin
            if (k > 0) @(negedge Clk);
            if (k >= 65 && k <= 128 && Buzzer === 1'b1) highs++;
            checks++;
            if (Buzzer !== exp_buzz(hps[n], lens[n], vols[n], note_e, k)) begin
               errors++;
               $display("FAIL volume_buzzer vol=%0d k=%0d: got %b expected %b",
                        vols[n], k, Buzzer, exp_buzz(hps[n], lens[n], vols[n], note_e, k));
            end
         end
         if (n == 0) begin
`ifdef ENVELOPE_DECAY_EN
            want = 8;
`else
            want = 16;
`endif
            checks++;
            if (highs !== want) begin
               errors++;
               $display("FAIL volume_duty: got %0d high cycles expected %0d", highs, want);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      launch(1, 30, 7);
      repeat (6) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      checks++;
      if ({Buzzer, busy, note_done} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset: got buz/busy/done=%b%b%b expected 000", Buzzer, busy, note_done);
      end
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         checks++;
         if ({Buzzer, busy, note_done} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset k=%0d: got buz/busy/done=%b%b%b expected 000",
                     k, Buzzer, busy, note_done);
         end
      end
   endtask

   task automatic test_random();
      int hp, len, vol, last, stop;
      int phh = 0, pl = 0, pv = 0, pe = 0, pk = 0;
      for (int n = 0; n < 30; n++) begin
         hp   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
         len  = $urandom_range(0, 40);
         vol  = $urandom_range(0, 7);
         last = (len < 1) ? 1 : len;
         stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, last)) : last + 1;
         launch(hp, len, vol);
         checks++;
         if (Buzzer !== exp_buzz(phh, pl, pv, pe, pk + 1) || busy !== 1'b1 || note_done !== 1'b0) begin
            errors++;
            $display("FAIL rand_start n=%0d: got buz/busy/done=%b%b%b expected %b10",
                     n, Buzzer, busy, note_done, exp_buzz(phh, pl, pv, pe, pk + 1));
         end
         for (int k = 1; k <= stop; k++) begin
            @(negedge Clk);
            checks++;
            if (Buzzer !== exp_buzz(hp, len, vol, note_e, k) ||
                busy !== (k < last) || note_done !== (k == last)) begin
               errors++;
               $display("FAIL rand n=%0d hp=%0d len=%0d vol=%0d k=%0d: got %b%b%b expected %b%b%b",
                        n, hp, len, vol, k, Buzzer, busy, note_done,
                        exp_buzz(hp, len, vol, note_e, k), k < last, k == last);
            end
         end
         phh = hp; pl = len; pv = vol; pe = note_e; pk = stop;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rest_and_short();
      test_back_to_back();
      test_volume();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
